// File: rtl/sccb_responder.sv
// ---------------------------------------------------------------------------
// sccb_responder
//   SCCB/I2C target that behaves like the camera's register port. SCL/SDA
//   are synchronised and filtered, START/STOP and bytes are decoded, the
//   device address is ACKed, and a 256 x 8 register file is written or read
//   back onto SDA. Used to close the configuration bus on-chip for loopback
//   bring-up and for sensor-less regression.
//
// Ports
//   clk_PS       processing clock (125 MHz)
//   db_rstn      asynchronous active-low reset
//   i_scl/i_sda  raw SCL/SDA line levels (asynchronous)
//   o_sda_oe     1 = pull SDA low, 0 = release
//   o_wr_strobe  one-cycle pulse per register write
//   o_wr_addr    register address of the last write
//   o_wr_data    data of the last write
//   o_busy       high from an addressed START until STOP
//   i_dbg_addr   debug read address
//   o_dbg_data   registered regfile[i_dbg_addr], 1-cycle latency
//
// Build option
//   SCCB_RESP_AUTOINC_EN  when defined, the register pointer increments after
//                         every written byte and every master-ACKed read byte.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sccb_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h21,
    parameter int          FILT_LEN = 3
) (
    input  logic       clk_PS,
    input  logic       db_rstn,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_strobe,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy,
    input  logic [7:0] i_dbg_addr,
    output logic [7:0] o_dbg_data
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ID        = 4'd1;
    localparam logic [3:0] ST_ID_ACK    = 4'd2;
    localparam logic [3:0] ST_SUB       = 4'd3;
    localparam logic [3:0] ST_SUB_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RD_MACK   = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    localparam logic [2:0] FILT_LAST = 3'(FILT_LEN - 1);

`ifdef SCCB_RESP_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    // Bit 1 = SCL, bit 0 = SDA. Reset to the idle-bus level (both high).
    logic [1:0] sync1_q, sync2_q, filt_q, prev_q;
    logic [2:0] sclCnt_q, sdaCnt_q;

    logic [3:0] state_q, state_d;
    logic [3:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       isRead_q, isRead_d;
    logic       ackDrive_q, ackDrive_d;
    logic       sdaOe_q, sdaOe_d;
    logic       busy_q, busy_d;
    logic       strobe_q, strobe_d;
    logic [7:0] wrAddr_q, wrAddr_d;
    logic [7:0] wrData_q, wrData_d;
    logic [7:0] dbg_q;
    logic [7:0] regFile_q [256];
    logic       wrEn;

    logic       sclRise, sclFall, startEv, stopEv;
    logic [7:0] byteIn, rdByte, ptrAfter;

    // A filtered level only follows the synchronised input after FILT_LEN
    // consecutive samples that differ from it; any shorter pulse resets the
    // count and is lost.
    always_ff @(posedge clk_PS or negedge db_rstn) begin
        if (!db_rstn) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            filt_q   <= 2'b11;
            prev_q   <= 2'b11;
            sclCnt_q <= 3'd0;
            sdaCnt_q <= 3'd0;
        end else begin
            sync1_q <= {i_scl, i_sda};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            if (sync2_q[1] == filt_q[1]) begin
                sclCnt_q <= 3'd0;
            end else if (sclCnt_q == FILT_LAST) begin
                filt_q[1] <= sync2_q[1];
                sclCnt_q  <= 3'd0;
            end else begin
                sclCnt_q <= sclCnt_q + 3'd1;
            end
            if (sync2_q[0] == filt_q[0]) begin
                sdaCnt_q <= 3'd0;
            end else if (sdaCnt_q == FILT_LAST) begin
                filt_q[0] <= sync2_q[0];
                sdaCnt_q  <= 3'd0;
            end else begin
                sdaCnt_q <= sdaCnt_q + 3'd1;
            end
        end
    end

    // START/STOP need SCL steadily high across the SDA transition.
    assign sclRise  = filt_q[1] & ~prev_q[1];
    assign sclFall  = ~filt_q[1] & prev_q[1];
    assign startEv  = ~filt_q[0] & prev_q[0] & filt_q[1] & prev_q[1];
    assign stopEv   = filt_q[0] & ~prev_q[0] & filt_q[1] & prev_q[1];
    assign byteIn   = {shift_q[6:0], filt_q[0]};
    assign rdByte   = regFile_q[ptr_q];
    assign ptrAfter = AUTOINC ? ptr_q + 8'd1 : ptr_q;

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        isRead_d   = isRead_q;
        ackDrive_d = ackDrive_q;
        sdaOe_d    = sdaOe_q;
        busy_d     = busy_q;
        strobe_d   = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        wrEn       = 1'b0;
        if (stopEv) begin
            state_d    = ST_IDLE;
            bitCnt_d   = 4'd0;
            ackDrive_d = 1'b0;
            sdaOe_d    = 1'b0;
            busy_d     = 1'b0;
        end else if (startEv) begin
            state_d    = ST_ID;
            bitCnt_d   = 4'd0;
            ackDrive_d = 1'b0;
            sdaOe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (sclRise) begin
                        shift_d  = byteIn;
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            bitCnt_d = 4'd0;
                            if (state_q == ST_ID) begin
                                if (byteIn[7:1] == DEV_ADDR) begin
                                    state_d  = ST_ID_ACK;
                                    isRead_d = byteIn[0];
                                    busy_d   = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_SUB) begin
                                ptr_d   = byteIn;
                                state_d = ST_SUB_ACK;
                            end else begin
                                wrEn     = 1'b1;
                                strobe_d = 1'b1;
                                wrAddr_d = ptr_q;
                                wrData_d = byteIn;
                                ptr_d    = ptrAfter;
                                state_d  = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall after the 8th rise pulls SDA low; the second
                // fall ends the ACK bit. For a read, that same fall already
                // presents the first data bit.
                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (sclFall) begin
                        if (!ackDrive_q) begin
                            sdaOe_d    = 1'b1;
                            ackDrive_d = 1'b1;
                        end else begin
                            ackDrive_d = 1'b0;
                            sdaOe_d    = 1'b0;
                            bitCnt_d   = 4'd0;
                            if (state_q == ST_ID_ACK && isRead_q) begin
                                state_d  = ST_RDATA;
                                sdaOe_d  = ~rdByte[7];
                                shift_d  = {rdByte[6:0], 1'b0};
                                bitCnt_d = 4'd1;
                            end else if (state_q == ST_ID_ACK) begin
                                state_d = ST_SUB;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                // bitCnt counts bits already driven; the fall after the
                // 8th bit hands SDA back to the master for its ACK/NACK.
                ST_RDATA: begin
                    if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            sdaOe_d  = 1'b0;
                            bitCnt_d = 4'd0;
                            state_d  = ST_RD_MACK;
                        end else begin
                            sdaOe_d  = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (sclRise) begin
                        if (!filt_q[0]) begin
                            ptr_d    = ptrAfter;
                            shift_d  = regFile_q[ptrAfter];
                            bitCnt_d = 4'd0;
                            state_d  = ST_RDATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_PS or negedge db_rstn) begin
        if (!db_rstn) begin
            state_q    <= ST_IDLE;
            bitCnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            isRead_q   <= 1'b0;
            ackDrive_q <= 1'b0;
            sdaOe_q    <= 1'b0;
            busy_q     <= 1'b0;
            strobe_q   <= 1'b0;
            wrAddr_q   <= 8'h00;
            wrData_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            isRead_q   <= isRead_d;
            ackDrive_q <= ackDrive_d;
            sdaOe_q    <= sdaOe_d;
            busy_q     <= busy_d;
            strobe_q   <= strobe_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
        end
    end

    always_ff @(posedge clk_PS or negedge db_rstn) begin
        if (!db_rstn) begin
            for (int k = 0; k < 256; k++) begin
                regFile_q[k] <= 8'h00;
            end
            dbg_q <= 8'h00;
        end else begin
            if (wrEn) begin
                regFile_q[ptr_q] <= byteIn;
            end
            dbg_q <= regFile_q[i_dbg_addr];
        end
    end

    assign o_sda_oe    = sdaOe_q;
    assign o_wr_strobe = strobe_q;
    assign o_wr_addr   = wrAddr_q;
    assign o_wr_data   = wrData_q;
    assign o_busy      = busy_q;
    assign o_dbg_data  = dbg_q;

endmodule

// File: tb/tb_sccb_responder.sv
// ---------------------------------------------------------------------------
// tb_sccb_responder
//   Bit-banged SCCB master driving sccb_responder through a wired-AND SDA
//   line. A transaction-level model (register array, pointer, expected
//   busy/SDA-drive, queue of expected writes) is checked against the DUT on
//   every settled SCL-high window, and a few literal values pin the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sccb_responder;

    localparam int H = 8;

`ifdef SCCB_RESP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk_PS  = 1'b0;
    logic       db_rstn = 1'b0;
    logic       sclM    = 1'b1;
    logic       sdaM    = 1'b1;
    logic [7:0] dbgAddr = 8'h00;
    logic       busSda;
    logic       sdaOe, wrStrobe, busy;
    logic [7:0] wrAddr, wrData, dbgData;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         strobeCount = 0;
    int         ackCount    = 0;

    logic [7:0]  modelRf [256];
    logic [7:0]  modelPtr = 8'h00;
    logic        expOe    = 1'b0;
    logic        expBusy  = 1'b0;
    logic        chkEn    = 1'b0;
    logic [15:0] strobeQ [$];
    logic [15:0] sbEntry;
    logic [7:0]  readBack;

    // Open-drain bus: the responder can only pull the master's level low.
    assign busSda = sdaM & ~sdaOe;

    always #4 clk_PS = ~clk_PS;

    sccb_responder #(
        .DEV_ADDR(7'h21),
        .FILT_LEN(3)
    ) dut (
        .clk_PS     (clk_PS),
        .db_rstn    (db_rstn),
        .i_scl      (sclM),
        .i_sda      (busSda),
        .o_sda_oe   (sdaOe),
        .o_wr_strobe(wrStrobe),
        .o_wr_addr  (wrAddr),
        .o_wr_data  (wrData),
        .o_busy     (busy),
        .i_dbg_addr (dbgAddr),
        .o_dbg_data (dbgData)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: settled outputs against the model while chkEn is
    // open, and every write strobe against the queue of expected writes.
    always @(negedge clk_PS) begin
        if (chkEn) begin
            checkOutput("sda_oe", 32'(sdaOe), 32'(expOe));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("dbg_data", 32'(dbgData), 32'(modelRf[dbgAddr]));
        end
        if (db_rstn && wrStrobe) begin
            strobeCount++;
            if (strobeQ.size() == 0) begin
                checkOutput("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                sbEntry = strobeQ.pop_front();
                checkOutput("wr_addr", 32'(wrAddr), 32'(sbEntry[15:8]));
                checkOutput("wr_data", 32'(wrData), 32'(sbEntry[7:0]));
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_PS);
        #1;
    endtask

    // One SCL period: SDA set mid-low, then SCL high with a check window.
    task automatic applyStimulus(input logic b, input logic eOe, input bit glitch, output logic sampled);
        waitCycles(H);
        sdaM  = b;
        expOe = eOe;
        waitCycles(H);
        sclM = 1'b1;
        waitCycles(H);
        chkEn   = 1'b1;
        sampled = busSda;
        waitCycles(H);
        chkEn = 1'b0;
        if (glitch) begin
            sclM = 1'b0;
            waitCycles(2);
            sclM = 1'b1;
            waitCycles(H);
        end
        sclM = 1'b0;
    endtask

    task automatic doStart();
        sdaM = 1'b1;
        waitCycles(H);
        sclM = 1'b1;
        waitCycles(2 * H);
        sdaM = 1'b0;
        waitCycles(2 * H);
        sclM = 1'b0;
    endtask

    task automatic doStop();
        waitCycles(H);
        sdaM  = 1'b0;
        expOe = 1'b0;
        waitCycles(H);
        sclM = 1'b1;
        waitCycles(2 * H);
        sdaM    = 1'b1;
        expBusy = 1'b0;
        waitCycles(2 * H);
        chkEn = 1'b1;
        waitCycles(4);
        chkEn = 1'b0;
    endtask

    // Eight data bits plus the ACK slot. Model side effects of the byte
    // (busy, register write) take hold before the 8th bit's check window.
    task automatic sendByte(input logic [7:0] v, input logic ackExp, input logic busyAfter,
                            input bit doWrite, input int glitchBit);
        logic s;
        logic ackSeen;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                expBusy = busyAfter;
                if (doWrite) begin
                    modelRf[modelPtr] = v;
                    strobeQ.push_back({modelPtr, v});
                end
            end
            applyStimulus(v[i], 1'b0, (i == glitchBit), s);
        end
        applyStimulus(1'b1, ackExp, 1'b0, s);
        ackSeen = ~s;
        if (ackSeen) ackCount++;
        checkOutput("ack", 32'(ackSeen), 32'(ackExp));
    endtask

    // Write transaction: bytes packed MSB-first, first one is the sub-address.
    task automatic writeTxn(input logic [7:0] id, input logic [31:0] bytes, input int n,
                            input int glitchByte, input int glitchBit);
        logic       match;
        logic [7:0] b;
        int         gb;
        match = (id[7:1] == 7'h21) && !id[0];
        doStart();
        sendByte(id, match, match ? 1'b1 : expBusy, 1'b0, -1);
        for (int k = 0; k < n; k++) begin
            b  = bytes[31 - 8 * k -: 8];
            gb = (k == glitchByte) ? glitchBit : -1;
            if (!match) begin
                sendByte(b, 1'b0, expBusy, 1'b0, gb);
            end else if (k == 0) begin
                sendByte(b, 1'b1, 1'b1, 1'b0, gb);
                modelPtr = b;
            end else begin
                sendByte(b, 1'b1, 1'b1, 1'b1, gb);
                if (AUTOINC) modelPtr = modelPtr + 8'd1;
            end
        end
        doStop();
    endtask

    // Read transaction: master ACKs all but the last byte.
    task automatic readTxn(input int n, output logic [7:0] firstByte);
        logic [7:0] v, got;
        logic       s, mAck;
        firstByte = 8'h00;
        doStart();
        sendByte(8'h43, 1'b1, 1'b1, 1'b0, -1);
        for (int k = 0; k < n; k++) begin
            v   = modelRf[modelPtr];
            got = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                applyStimulus(1'b1, ~v[i], 1'b0, s);
                got = {got[6:0], s};
            end
            checkOutput("rd_byte", 32'(got), 32'(v));
            if (k == 0) firstByte = got;
            mAck = (k < n - 1);
            applyStimulus(mAck ? 1'b0 : 1'b1, 1'b0, 1'b0, s);
            if (mAck && AUTOINC) modelPtr = modelPtr + 8'd1;
        end
        doStop();
    endtask

    task automatic readDbg(input logic [7:0] addr, input logic [7:0] exp, input string name);
        dbgAddr = addr;
        waitCycles(2);
        checkOutput(name, 32'(dbgData), 32'(exp));
    endtask

    task automatic resetModel();
        for (int k = 0; k < 256; k++) modelRf[k] = 8'h00;
        modelPtr = 8'h00;
        expBusy  = 1'b0;
        expOe    = 1'b0;
    endtask

    initial begin
        logic       s;
        logic [7:0] rv;
        resetModel();

        // Reset state
        db_rstn = 1'b0;
        waitCycles(3);
        checkOutput("rst_sda_oe", 32'(sdaOe), 32'd0);
        checkOutput("rst_strobe", 32'(wrStrobe), 32'd0);
        checkOutput("rst_wr_addr", 32'(wrAddr), 32'd0);
        checkOutput("rst_wr_data", 32'(wrData), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_dbg", 32'(dbgData), 32'd0);
        db_rstn = 1'b1;
        waitCycles(5);

        // Basic write 0x12 <= 0x80
        dbgAddr = 8'h12;
        writeTxn(8'h42, {8'h12, 8'h80, 16'h0000}, 2, -1, -1);
        checkOutput("w1_ack_count", 32'(ackCount), 32'd3);
        checkOutput("w1_strobe_count", 32'(strobeCount), 32'd1);
        checkOutput("w1_wr_addr", 32'(wrAddr), 32'h12);
        checkOutput("w1_wr_data", 32'(wrData), 32'h80);
        readDbg(8'h12, 8'h80, "w1_dbg");

        // Preload 0x0A, set pointer, read one byte back and NACK
        dbgAddr = 8'h0A;
        writeTxn(8'h42, {8'h0A, 8'hA5, 16'h0000}, 2, -1, -1);
        writeTxn(8'h42, {8'h0A, 24'h000000}, 1, -1, -1);
        readTxn(1, readBack);
        checkOutput("rd_literal", 32'(readBack), 32'hA5);
        checkOutput("rd_busy_after_stop", 32'(busy), 32'd0);

        // Foreign device address: no ACK, no write, not busy
        writeTxn(8'h60, {8'h12, 8'h55, 16'h0000}, 2, -1, -1);
        checkOutput("wrong_id_strobes", 32'(strobeCount), 32'd2);
        checkOutput("wrong_id_busy", 32'(busy), 32'd0);
        readDbg(8'h12, 8'h80, "wrong_id_dbg");

        // Two data bytes starting at 0xFF
        dbgAddr = 8'hFF;
        writeTxn(8'h42, {8'hFF, 8'h11, 8'h22, 8'h00}, 3, -1, -1);
`ifdef SCCB_RESP_AUTOINC_EN
        readDbg(8'hFF, 8'h11, "ptr_ff_dbg");
        readDbg(8'h00, 8'h22, "ptr_wrap_dbg");
`else
        readDbg(8'hFF, 8'h22, "ptr_ff_dbg");
        readDbg(8'h00, 8'h00, "ptr_wrap_dbg");
`endif

        // Short SCL low glitch inside a data byte
        dbgAddr = 8'h30;
        writeTxn(8'h42, {8'h30, 8'h5A, 16'h0000}, 2, 1, 4);
        readDbg(8'h30, 8'h5A, "glitch_dbg");
        checkOutput("glitch_wr_data", 32'(wrData), 32'h5A);

        // Reset during the 4th bit of a data byte
        doStart();
        sendByte(8'h42, 1'b1, 1'b1, 1'b0, -1);
        sendByte(8'h44, 1'b1, 1'b1, 1'b0, -1);
        modelPtr = 8'h44;
        rv = 8'hC3;
        for (int i = 7; i >= 5; i--) applyStimulus(rv[i], 1'b0, 1'b0, s);
        waitCycles(H);
        sdaM = rv[4];
        waitCycles(4);
        db_rstn = 1'b0;
        #1;
        checkOutput("mid_rst_sda_oe", 32'(sdaOe), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_wr_addr", 32'(wrAddr), 32'd0);
        checkOutput("mid_rst_wr_data", 32'(wrData), 32'd0);
        resetModel();
        waitCycles(3);
        db_rstn = 1'b1;
        waitCycles(2);
        readDbg(8'h30, 8'h00, "mid_rst_cleared");
        doStop();
        checkOutput("mid_rst_strobes", 32'(strobeCount), 32'd5);

        // Full write after reset
        dbgAddr = 8'h44;
        writeTxn(8'h42, {8'h44, 8'h99, 16'h0000}, 2, -1, -1);
        readDbg(8'h44, 8'h99, "post_rst_dbg");
        checkOutput("post_rst_wr_addr", 32'(wrAddr), 32'h44);

        checkOutput("strobe_pending", 32'(strobeQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
